// File: rtl/clken_gen_if.sv
// ---------------------------------------------------------------------------
// clken_gen_if
//   Bundle of control inputs and clock-enable outputs exchanged between the
//   clock-enable generator and the logic it paces.
//
//   turbo     : CPU speed select (period 2^(CPU_LOG2-turbo) cycles)
//   pause     : suppress CPU enables, freeze ROM-ready delay
//   restart   : one-cycle request re-arming the ROM-ready delay
//   ce_pix    : pixel clock-enable pulse
//   ce_cpu    : CPU rising-phase enable pulse
//   ce_cpu_n  : CPU half-phase enable pulse
//   rom_ready : sticky "ROM load delay elapsed" flag
//
//   master : the consumer side (drives controls, receives enables)
//   slave  : the generator side
// ---------------------------------------------------------------------------
interface clken_gen_if #(
    parameter int TURBO_W = 2
);
    logic [TURBO_W-1:0] turbo;
    logic               pause;
    logic               restart;
    logic               ce_pix;
    logic               ce_cpu;
    logic               ce_cpu_n;
    logic               rom_ready;

    modport master (
        output turbo, pause, restart,
        input  ce_pix, ce_cpu, ce_cpu_n, rom_ready
    );

    modport slave (
        input  turbo, pause, restart,
        output ce_pix, ce_cpu, ce_cpu_n, rom_ready
    );
endinterface

// File: rtl/clken_gen.sv
// ---------------------------------------------------------------------------
// clken_gen
//   Derives pixel and CPU clock-enable pulses from a single free-running
//   divider, and produces a sticky ROM-ready flag once a programmable number
//   of CPU enables has elapsed.
//
//   Ports:
//     clk_sys : system clock, all logic on the rising edge
//     reset_n : asynchronous active-low reset
//     bus     : clken_gen_if.slave (turbo/pause/restart in,
//               ce_pix/ce_cpu/ce_cpu_n/rom_ready out)
//
//   Parameters:
//     PIX_LOG2  : ce_pix period is 2^PIX_LOG2 cycles (1..8)
//     CPU_LOG2  : slowest ce_cpu period is 2^CPU_LOG2 cycles (1..8)
//     TURBO_W   : width of the turbo select
//     READY_CNT : ce_cpu pulses from reset release to rom_ready
// ---------------------------------------------------------------------------
module clken_gen #(
    parameter int          PIX_LOG2  = 3,
    parameter int          CPU_LOG2  = 4,
    parameter int          TURBO_W   = 2,
    parameter logic [23:0] READY_CNT = 24'hFFFFFF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    clken_gen_if.slave  bus
);

    localparam int DIV_W = (PIX_LOG2 > CPU_LOG2) ? PIX_LOG2 : CPU_LOG2;

    logic [DIV_W-1:0]   div;
    logic [TURBO_W-1:0] turbo_l;
    logic [23:0]        ready_cnt;

    logic               ce_pix_q;
    logic               ce_cpu_q;
    logic               ce_cpu_n_q;
    logic               rom_ready_q;

    // Decode of the current divider value; results are registered below.
    logic [3:0]         shift;
    logic [8:0]         div_ext;
    logic [8:0]         cpu_mask;
    logic [8:0]         half_pt;
    logic               pix_hit;
    logic               cpu_hit;
    logic               cpun_hit;
    logic               ce_cpu_d;
    logic               slow_wrap;

    always_comb begin
        // Effective shift: CPU_LOG2 - turbo_l, clamped at zero.
        shift = 4'd0;
        if (int'(turbo_l) < CPU_LOG2)
            shift = 4'(CPU_LOG2 - int'(turbo_l));

        div_ext  = 9'(div);
        cpu_mask = (9'd1 << shift) - 9'd1;
        half_pt  = 9'd0;
        if (shift != 4'd0)
            half_pt = 9'd1 << (shift - 4'd1);

        pix_hit  = (div[PIX_LOG2-1:0] == '0);
        // With shift=0 the mask is empty, so ce_cpu fires every cycle and
        // the half-phase enable has no slot of its own.
        cpu_hit  = ((div_ext & cpu_mask) == 9'd0);
        cpun_hit = (shift != 4'd0) && ((div_ext & cpu_mask) == half_pt);
        ce_cpu_d = cpu_hit && !bus.pause;

        // Speed changes only land at the end of a slowest period so no
        // pulse is ever shortened or doubled mid-period.
        slow_wrap = &div[CPU_LOG2-1:0];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div         <= '0;
            turbo_l     <= '0;
            ready_cnt   <= '0;
            ce_pix_q    <= 1'b0;
            ce_cpu_q    <= 1'b0;
            ce_cpu_n_q  <= 1'b0;
            rom_ready_q <= 1'b0;
        end else begin
            div        <= div + DIV_W'(1);
            if (slow_wrap)
                turbo_l <= bus.turbo;

            ce_pix_q   <= pix_hit;
            ce_cpu_q   <= ce_cpu_d;
            ce_cpu_n_q <= cpun_hit && !bus.pause;

            // Ready counter counts the ce_cpu pulses being registered this
            // edge, so rom_ready follows one cycle after the final pulse.
            if (bus.restart) begin
                ready_cnt   <= '0;
                rom_ready_q <= 1'b0;
            end else begin
                if (ce_cpu_d && (ready_cnt != READY_CNT))
                    ready_cnt <= ready_cnt + 24'd1;
                if (ready_cnt == READY_CNT)
                    rom_ready_q <= 1'b1;
            end
        end
    end

    assign bus.ce_pix    = ce_pix_q;
    assign bus.ce_cpu    = ce_cpu_q;
    assign bus.ce_cpu_n  = ce_cpu_n_q;
    assign bus.rom_ready = rom_ready_q;

endmodule
